lc3_mem_responder: RTL

//   Memory-side responder for the LC3 instruction and data memory ports. It answers
//   pc/instrmem_rd with Instr_dout/complete_instr, and Data_addr/Data_rd/Data_din with

---
 rtl/lc3_mem_pkg.sv | 27 ++
 rtl/lc3_mem_port_fsm.sv | 83 ++++++++
 rtl/lc3_mem_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_pkg.sv
// ---------------------------------------------------------------------------
// lc3_mem_pkg
//   Shared types and constants for the LC3 memory responder.
//   - mem_state_e : per-port FSM state (IDLE -> WAIT -> DONE -> IDLE)
//   - LC3_WORD_W  : memory word width
//   - LFSR_SEED / LFSR_TAPS / lfsr_next : random wait-state generator used
//     only when LC3_MEM_LFSR_WAIT_EN is defined
// ---------------------------------------------------------------------------
package lc3_mem_pkg;

  localparam int LC3_WORD_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lc3_mem_port_fsm.sv
// ---------------------------------------------------------------------------
// lc3_mem_port_fsm
//   Request sequencer for one memory port. Accepts a held-high request,
//   latches the request payload, counts LAT-1 (+extra_wait) wait cycles and
//   then spends one cycle in DONE, during which do_access is high and the
//   owner performs the array access.
//
//   Handshake: req is a level request held high by the master until the
//   owner's completion pulse. A request seen in IDLE is accepted on that edge.
//   Dropping req while in WAIT aborts the access (no DONE, no access).
//   A request still high when the FSM is back in IDLE is a new request.
//
// Parameters
//   LAT    wait states (>=1)
//   PAY_W  width of the latched request payload
// Ports
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low
//   req          in   request level
//   req_payload  in   request fields, sampled at accept
//   extra_wait   in   additional wait states added at accept (0-3)
//   payload      out  latched request fields
//   do_access    out  high for the single DONE cycle
//   state        out  current FSM state (debug)
// ---------------------------------------------------------------------------
module lc3_mem_port_fsm
  import lc3_mem_pkg::*;
#(
  parameter int LAT   = 1,
  parameter int PAY_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [PAY_W-1:0] req_payload,
  input  logic [1:0]       extra_wait,
  output logic [PAY_W-1:0] payload,
  output logic             do_access,
  output mem_state_e       state
);

  // Counter must hold LAT-1 plus up to 3 extra wait states.
  localparam int CNT_W = $clog2(LAT + 4);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      payload <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            payload <= req_payload;
            cnt     <= CNT_W'(LAT - 1) + CNT_W'(extra_wait);
            state   <= WAIT;
          end
        end
        WAIT: begin
          // Abort has priority: a withdrawn request must never complete.
          if (!req) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign do_access = (state == DONE);

endmodule

// File: rtl/lc3_mem_responder.sv
// ---------------------------------------------------------------------------
// lc3_mem_responder
//   Synthesizable backing memory for the LC3 core. Two independent ports
//   (instruction fetch and data access) each run their own request FSM and
//   complete after a fixed number of wait states. A preload strobe lets the
//   bench write words on any edge.
//
//   Handshake: instrmem_rd / data_req are held high until the matching
//   complete_* pulse. complete_* is a registered one-cycle pulse that rises
//   LAT+1 cycles after the accept edge; dout holds its value until the next
//   completion on that port.
//
//   Array write ordering on one edge: the data-port write commits first and a
//   preload to the same word overrides it. Reads in the DONE cycle see the
//   word as it will be after that edge (write-first bypass, preload highest).
//
//   Optional feature: define LC3_MEM_LFSR_WAIT_EN to add 0-3 pseudo-random
//   wait states per access from a free-running 16-bit LFSR.
//
// Parameters
//   ADDR_W  index bits into the word array (upper address bits ignored)
//   I_LAT   instruction wait states (>=1)
//   D_LAT   data wait states (>=1)
// Ports
//   clk, reset                      clock, async active-low reset
//   instrmem_rd, pc                 fetch request and address
//   Instr_dout, complete_instr      fetched word and done pulse
//   data_req, Data_rd, Data_addr,
//   Data_din                        data request, direction, address, wdata
//   Data_dout, complete_data        read data (0 for writes) and done pulse
//   ld_en, ld_addr, ld_data         preload strobe, address, word
//   instr_state_dbg, data_state_dbg per-port FSM state (debug)
// ---------------------------------------------------------------------------
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int I_LAT  = 1,
  parameter int D_LAT  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instrmem_rd,
  input  logic [LC3_WORD_W-1:0] pc,
  output logic [LC3_WORD_W-1:0] Instr_dout,
  output logic                  complete_instr,
  input  logic                  data_req,
  input  logic                  Data_rd,
  input  logic [LC3_WORD_W-1:0] Data_addr,
  input  logic [LC3_WORD_W-1:0] Data_din,
  output logic [LC3_WORD_W-1:0] Data_dout,
  output logic                  complete_data,
  input  logic                  ld_en,
  input  logic [LC3_WORD_W-1:0] ld_addr,
  input  logic [LC3_WORD_W-1:0] ld_data,
  output mem_state_e            instr_state_dbg,
  output mem_state_e            data_state_dbg
);

  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int D_PAY_W = ADDR_W + LC3_WORD_W + 1;

  // -------------------------------------------------------------------------
  // Wait-state randomisation
  // -------------------------------------------------------------------------
  logic [1:0] extra_wait;

`ifdef LC3_MEM_LFSR_WAIT_EN
  logic [15:0] lfsr;
  logic        lfsr_unused;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  assign extra_wait  = lfsr[1:0];
  assign lfsr_unused = ^lfsr[15:2];
`else
  assign extra_wait = 2'b00;
`endif

  // Upper address bits are deliberately ignored.
  generate
    if (ADDR_W < LC3_WORD_W) begin : g_addr_unused
      logic addr_unused;
      assign addr_unused = ^{pc[LC3_WORD_W-1:ADDR_W],
                             Data_addr[LC3_WORD_W-1:ADDR_W],
                             ld_addr[LC3_WORD_W-1:ADDR_W]};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Port sequencers
  // -------------------------------------------------------------------------
  logic [ADDR_W-1:0]  i_idx;
  logic               i_access;

  logic [D_PAY_W-1:0] d_payload;
  logic               d_access;
  logic               d_rd;
  logic [15:0]        d_din;
  logic [ADDR_W-1:0]  d_idx;

  lc3_mem_port_fsm #(
    .LAT   (I_LAT),
    .PAY_W (ADDR_W)
  ) u_instr_fsm (
    .clk         (clk),
    .reset       (reset),
    .req         (instrmem_rd),
    .req_payload (pc[ADDR_W-1:0]),
    .extra_wait  (extra_wait),
    .payload     (i_idx),
    .do_access   (i_access),
    .state       (instr_state_dbg)
  );

  lc3_mem_port_fsm #(
    .LAT   (D_LAT),
    .PAY_W (D_PAY_W)
  ) u_data_fsm (
    .clk         (clk),
    .reset       (reset),
    .req         (data_req),
    .req_payload ({Data_rd, Data_din, Data_addr[ADDR_W-1:0]}),
    .extra_wait  (extra_wait),
    .payload     (d_payload),
    .do_access   (d_access),
    .state       (data_state_dbg)
  );

  assign d_rd  = d_payload[D_PAY_W-1];
  assign d_din = d_payload[ADDR_W +: LC3_WORD_W];
  assign d_idx = d_payload[ADDR_W-1:0];

  // -------------------------------------------------------------------------
  // Word array and write arbitration
  // -------------------------------------------------------------------------
  logic [LC3_WORD_W-1:0] mem [0:DEPTH-1];
  logic [ADDR_W-1:0]     ld_idx;
  logic                  wr_commit;

  assign ld_idx    = ld_addr[ADDR_W-1:0];
  assign wr_commit = d_access && !d_rd;

  // Not reset: contents survive reset so preloaded programs are retained.
  // The preload write comes last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (wr_commit) begin
      mem[d_idx] <= d_din;
    end
    if (ld_en) begin
      mem[ld_idx] <= ld_data;
    end
  end

  // -------------------------------------------------------------------------
  // Read paths with bypass (preload > committing data write > array)
  // -------------------------------------------------------------------------
  logic [LC3_WORD_W-1:0] i_word;
  logic [LC3_WORD_W-1:0] d_word;

  always_comb begin
    i_word = mem[i_idx];
    if (wr_commit && (d_idx == i_idx)) begin
      i_word = d_din;
    end
    if (ld_en && (ld_idx == i_idx)) begin
      i_word = ld_data;
    end
  end

  // The data port never reads and writes in the same cycle, so only the
  // preload bypass can apply here.
  always_comb begin
    d_word = mem[d_idx];
    if (ld_en && (ld_idx == d_idx)) begin
      d_word = ld_data;
    end
  end

  // -------------------------------------------------------------------------
  // Registered responses
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Instr_dout     <= '0;
      complete_instr <= 1'b0;
    end else begin
      complete_instr <= i_access;
      if (i_access) begin
        Instr_dout <= i_word;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      Data_dout     <= '0;
      complete_data <= 1'b0;
    end else begin
      complete_data <= d_access;
      if (d_access) begin
        Data_dout <= d_rd ? d_word : '0;
      end
    end
  end

endmodule
